// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for serial_addsub; slave is the adder's view.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, y, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, y, carry_out, overflow, zero
    );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per cycle, LSB first,
// with a valid/ready operand port and a held result port.
module serial_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 8
) (
    input logic           clk,
    input logic           rst,
    serial_addsub_if.slave bus
);
    localparam int unsigned DSAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int unsigned N     = WIDTH / DSAFE;
    localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;

    generate
        if ((DIGIT < 1) || ((WIDTH % DSAFE) != 0)) begin : g_bad_params
            $error("serial_addsub: DIGIT must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [DIGIT:0]   sum;

    // Operands shift right each RUN cycle so the live digit is always in the low
    // bits; result digits enter y from the top. Operand MSBs are kept for overflow.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        y_d      = y_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        carry_d  = carry_q;
        k_d      = k_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        sum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
                    carry_d = bus.sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                y_d     = (y_q >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
                carry_d = sum[DIGIT];
                k_d     = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    state_d = DONE;
                    cout_d  = sum[DIGIT];
                    zero_d  = ~|y_d;
                    ovf_d   = (a_msb_q == b_msb_q) & (y_d[WIDTH-1] != a_msb_q);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            y_q         <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            y_q         <= y_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            carry_q     <= carry_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule
